// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p2s_pkg
// Purpose  : Shared types and constants for the parallel-to-serial transmit
//            scheduler: FSM state encoding, default widths and an index-width
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package p2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } p2s_state_e;

   localparam int P2S_DATA_W  = 4;
   localparam int P2S_NUM_REQ = 4;

   // Width of an index able to address n items; never less than one bit.
   function automatic int p2s_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : p2s_pkg
`default_nettype wire

// File: rtl/p2s_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : p2s_shift_reg
// Purpose  : DATA_W-bit parallel-load, shift-right register. Bit 0 is the
//            serial output; zeros are shifted in at the MSB.
// Ports    : clk_i    - clock, rising edge
//            reset_i  - synchronous active-high reset
//            load_i   - load data_i (has priority over shift_i)
//            shift_i  - shift right by one with zero fill
//            data_i   - parallel load value
//            bit0_o   - current LSB
// Revision : 1.0 - initial release
// ============================================================================
module p2s_shift_reg
   import p2s_pkg::*;
#(
   parameter int DATA_W = P2S_DATA_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              bit0_o
);

   logic [DATA_W-1:0] shreg_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shreg_q <= '0;
      end else if (load_i) begin
         shreg_q <= data_i;
      end else if (shift_i) begin
         shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
      end
   end

   assign bit0_o = shreg_q[0];

endmodule : p2s_shift_reg
`default_nettype wire

// File: rtl/p2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : p2s_tx_scheduler
// Purpose  : Round-robin scheduler sharing one parallel-to-serial shifter
//            among NUM_REQ nibble requesters. Each frame is DATA_W bits, LSB
//            first, followed by GAP_CYCLES idle cycles.
// Ports    : clk_i          - clock, rising edge
//            reset_i        - synchronous active-high reset
//            req_valid_i    - per-requester valid
//            req_data_i     - packed nibbles, requester i at [i*DATA_W +: DATA_W]
//            req_ready_o    - one-hot accept pulse (LOAD cycle)
//            serial_out_o   - serial data, LSB first
//            frame_active_o - high while serial_out_o carries a bit
//            grant_id_o     - requester owning the shifter
//            frame_done_o   - pulse on the last bit of a frame
//            busy_o         - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module p2s_tx_scheduler
   import p2s_pkg::*;
#(
   parameter int NUM_REQ    = P2S_NUM_REQ,
   parameter int DATA_W     = P2S_DATA_W,
   parameter int GAP_CYCLES = 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic                        serial_out_o,
   output logic                        frame_active_o,
   output logic [p2s_idx_w(NUM_REQ)-1:0] grant_id_o,
   output logic                        frame_done_o,
   output logic                        busy_o
);

   localparam int              GW       = p2s_idx_w(NUM_REQ);
   localparam int              CW       = p2s_idx_w(DATA_W);
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
   // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
   localparam logic [3:0]      LAST_GAP = 4'(GAP_CYCLES - 1);
   localparam logic [GW-1:0]   RST_LAST = GW'(NUM_REQ - 1);

   p2s_state_e        state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     last_q,  last_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic [3:0]        gap_q,   gap_d;
   logic              load_en;
   logic              shift_en;
   logic              shreg_bit0;
   logic [DATA_W-1:0] load_data;

   // First valid requester after 'last', wrapping; 'last' itself has the
   // lowest priority. Iterating from the farthest candidate down lets the
   // nearest one overwrite the result.
   function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [GW-1:0]      last);
      logic [GW-1:0] pick;
      int            idx;
      pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (valid[idx]) begin
            pick = GW'(idx);
         end
      end
      return pick;
   endfunction

   assign load_data = req_data_i[int'(grant_q)*DATA_W +: DATA_W];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= RST_LAST;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      load_en  = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               grant_d = rr_pick(req_valid_i, last_q);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A requester that withdrew before acceptance forfeits the slot
            // without advancing the round-robin pointer.
            if (req_valid_i[grant_q]) begin
               load_en = 1'b1;
               cnt_d   = '0;
               last_d  = grant_q;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               cnt_d = '0;
               if (GAP_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_d   = '0;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == LAST_GAP) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   p2s_shift_reg #(
      .DATA_W (DATA_W)
   ) u_shift_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (load_en),
      .shift_i (shift_en),
      .data_i  (load_data),
      .bit0_o  (shreg_bit0)
   );

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
         assign req_ready_o[i] = (state_q == ST_LOAD) && (grant_q == GW'(i)) && req_valid_i[i];
      end
   endgenerate

   assign frame_active_o = (state_q == ST_SHIFT);
   assign serial_out_o   = frame_active_o & shreg_bit0;
   assign frame_done_o   = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
   assign grant_id_o     = grant_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule : p2s_tx_scheduler
`default_nettype wire

// File: tb/tb_p2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_p2s_tx_scheduler
// Purpose  : Self-checking bench for p2s_tx_scheduler. Two instances share the
//            same stimulus, one with a one-cycle gap and one without. A
//            frame-schedule reference model predicts every output each cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_p2s_tx_scheduler;

   localparam int N   = 4;
   localparam int DW  = 4;
   localparam int INF = 1 << 30;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;

   logic [N-1:0]  rdy_a, rdy_b;
   logic          ser_a, ser_b, fa_a, fa_b, fd_a, fd_b, bsy_a, bsy_b;
   logic [1:0]    gid_a, gid_b;

   always #5 clk = ~clk;

   p2s_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(1)) u_dut_gap1 (
      .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
      .req_ready_o(rdy_a), .serial_out_o(ser_a), .frame_active_o(fa_a),
      .grant_id_o(gid_a), .frame_done_o(fd_a), .busy_o(bsy_a));

   p2s_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(0)) u_dut_gap0 (
      .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
      .req_ready_o(rdy_b), .serial_out_o(ser_b), .frame_active_o(fa_b),
      .grant_id_o(gid_b), .frame_done_o(fd_b), .busy_o(bsy_b));

   // Reference model: each unit is described by the cycle of its pending LOAD,
   // the cycle of its first serial bit, and the first cycle it is idle again.
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          armed    = 1'b0;
   int          gap_len [2];
   int          t_load  [2];
   int          t_first [2];
   int          t_free  [2];
   int          last_m  [2];
   int          grant_m [2];
   logic [DW-1:0] nib_m [2];

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return last;
   endfunction

   task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[u%0d] cycle %0d: observed %0h expected %0h", tag, u, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int u = 0; u < 2; u++) begin
         bit           in_load, in_frame, idle;
         logic [N-1:0] er;
         logic         eser;
         in_load  = (cyc == t_load[u]);
         in_frame = (cyc >= t_first[u]) && (cyc < t_first[u] + DW);
         idle     = (cyc >= t_free[u]);
         er       = '0;
         if (in_load && req_valid[grant_m[u]]) er[grant_m[u]] = 1'b1;
         eser = 1'b0;
         if (in_frame) eser = nib_m[u][cyc - t_first[u]];
         chk("busy",         u, 32'(u == 0 ? bsy_a : bsy_b), 32'(!idle));
         chk("frame_active", u, 32'(u == 0 ? fa_a  : fa_b),  32'(in_frame));
         chk("serial_out",   u, 32'(u == 0 ? ser_a : ser_b), 32'(eser));
         chk("frame_done",   u, 32'(u == 0 ? fd_a  : fd_b),  32'(in_frame && (cyc == t_first[u] + DW - 1)));
         chk("req_ready",    u, 32'(u == 0 ? rdy_a : rdy_b), 32'(er));
         chk("grant_id",     u, 32'(u == 0 ? gid_a : gid_b), 32'(grant_m[u]));
      end
   endtask

   task automatic advance(input logic r);
      for (int u = 0; u < 2; u++) begin
         if (r) begin
            t_load[u]  = -100;
            t_first[u] = -100;
            t_free[u]  = cyc + 1;
            last_m[u]  = N - 1;
            grant_m[u] = 0;
         end else if (cyc == t_load[u]) begin
            if (req_valid[grant_m[u]]) begin
               nib_m[u]   = req_data[grant_m[u]*DW +: DW];
               last_m[u]  = grant_m[u];
               t_first[u] = cyc + 1;
               t_free[u]  = cyc + 1 + DW + gap_len[u];
            end else begin
               t_free[u]  = cyc + 1;
            end
         end else if (cyc >= t_free[u] && (|req_valid)) begin
            grant_m[u] = rr_pick(req_valid, last_m[u]);
            t_load[u]  = cyc + 1;
            t_free[u]  = INF;
         end
      end
   endtask

   // One clock cycle: drive inputs, let outputs settle, compare, advance model.
   task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
      req_valid = v;
      req_data  = d;
      rst       = r;
      #2;
      if (armed) check_all();
      advance(r);
      if (r) armed = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0]    v;
      logic [N*DW-1:0] d;
      logic            r;
      gap_len[0] = 1;
      gap_len[1] = 0;
      for (int u = 0; u < 2; u++) begin
         t_load[u] = -100; t_first[u] = -100; t_free[u] = 0;
         last_m[u] = N - 1; grant_m[u] = 0; nib_m[u] = '0;
      end
      req_valid = '0;
      req_data  = '0;
      rst       = 1'b1;
      @(posedge clk);
      #1;

      // Reset
      for (int k = 0; k < 3; k++) step('0, '0, 1'b1);

      // Single request from requester 2 with nibble 1011
      for (int k = 0; k < 2; k++) step(4'b0100, 16'h0B00, 1'b0);
      for (int k = 0; k < 8; k++) step(4'b0000, 16'h0B00, 1'b0);

      // Requester 1 withdraws during LOAD: no accept, pointer unchanged
      step(4'b0010, 16'h0050, 1'b0);
      for (int k = 0; k < 4; k++) step(4'b0000, 16'h0050, 1'b0);

      // All requesters valid continuously, nibbles 1,2,3,4
      for (int k = 0; k < 36; k++) step(4'b1111, 16'h4321, 1'b0);
      for (int k = 0; k < 8; k++) step(4'b0000, 16'h4321, 1'b0);

      // Reset on the third SHIFT cycle, then requester 0 must win first
      for (int k = 0; k < 4; k++) step(4'b0001, 16'h0007, 1'b0);
      step(4'b0001, 16'h0007, 1'b1);
      for (int k = 0; k < 10; k++) step(4'b1111, 16'hA5C3, 1'b0);
      for (int k = 0; k < 8; k++) step(4'b0000, 16'hA5C3, 1'b0);

      // Requester 0 toggles mid-frame while requester 2 stays valid
      for (int k = 0; k < 24; k++) step(4'b0100 | 4'((k % 3) == 0), 16'h09E6, 1'b0);
      for (int k = 0; k < 8; k++) step(4'b0000, 16'h09E6, 1'b0);

      // Randomized traffic: data only changes while its valid is low
      v = '0;
      d = '0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < N; i++) begin
            if (v[i]) begin
               if ($urandom_range(3) == 0) v[i] = 1'b0;
            end else begin
               d[i*DW +: DW] = DW'($urandom);
               if ($urandom_range(1) == 0) v[i] = 1'b1;
            end
         end
         r = ($urandom_range(199) == 0);
         step(v, d, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_p2s_tx_scheduler
`default_nettype wire
